// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, oversampled start detection with
// mid-bit glitch rejection, LSB-first data capture and stop-bit framing check.
// All sequencing advances only on baud_tick strobes from an external divider.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_DATA  = 2'b10,
        S_STOP  = 2'b11
    } state_t;

    state_t                 state_q, state_d;
    logic [TICK_W-1:0]      tick_q, tick_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   ferr_q, ferr_d;
    logic                   valid_q, valid_d;
    logic                   rx_meta_q, rx_s_q;
    logic                   stop_sample;

    // Bring the asynchronous line into the clock domain; idles high out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Next-state logic: every counter and state move is gated by baud_tick,
    // except the rx_valid pulse which always drops on the following cycle.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        data_d      = data_q;
        ferr_d      = ferr_q;
        valid_d     = 1'b0;
        stop_sample = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (baud_tick && !rx_s_q) begin
                    state_d = S_START;
                    tick_d  = '0;
                end
            end

            S_START: begin
                if (baud_tick) begin
                    if (tick_q == TICK_MID) begin
                        if (!rx_s_q) begin
                            state_d = S_DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end else begin
                            // Line returned high before mid-bit: treat as a glitch.
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end

            S_DATA: begin
                if (baud_tick) begin
                    if (tick_q == TICK_LAST) begin
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        tick_d  = '0;
                        bit_d   = bit_q + BIT_W'(1);
                        if (bit_q == BIT_LAST) begin
                            state_d = S_STOP;
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end

            S_STOP: begin
                if (baud_tick) begin
                    if (tick_q == TICK_LAST) begin
                        // Deliver the word even on a bad stop bit; flag it instead.
                        stop_sample = 1'b1;
                        data_d      = shift_q;
                        ferr_d      = ~rx_s_q;
                        valid_d     = 1'b1;
                        tick_d      = '0;
                        state_d     = S_IDLE;
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Register all receiver state; reset abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            ferr_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ferr_q  <= ferr_d;
            valid_q <= valid_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);

    a_valid_single : assert property (@(posedge clk) disable iff (rst)
        valid_q |=> !valid_q);

    a_busy_state : assert property (@(posedge clk)
        busy == (state_q != S_IDLE));

    a_valid_cause : assert property (@(posedge clk) disable iff (rst)
        valid_q |-> $past(stop_sample));

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: table of frames plus hand-written sequences
// for glitch rejection, line break and reset in the middle of a frame.
module tb_uart_rx;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;
    // Baud strobe every few clocks keeps frames short; the receiver only counts strobes.
    localparam int TICK_DIV   = 4;

    logic                 clk;
    logic                 rst;
    logic                 baud_tick;
    logic                 rx;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [DATA_BITS:0] capq[$];
    logic               prev_valid = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[6];

    uart_rx #(
        .DATA_BITS (DATA_BITS),
        .OVERSAMPLE(OVERSAMPLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .baud_tick(baud_tick),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-cycle baud strobe every TICK_DIV clocks, changed on the falling edge.
    initial begin
        int div_cnt;
        div_cnt   = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            baud_tick = (div_cnt == TICK_DIV - 1);
            div_cnt   = (div_cnt == TICK_DIV - 1) ? 0 : div_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Capture every delivered word and confirm the valid pulse lasts one cycle.
    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            check("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
            capq.push_back({frame_err, rx_data});
        end
        prev_valid = rx_valid;
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (baud_tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop);
        rx = 1'b0;
        wait_ticks(OVERSAMPLE);
        for (int k = 0; k < DATA_BITS; k++) begin
            rx = data[k];
            wait_ticks(OVERSAMPLE);
        end
        rx = stop;
        wait_ticks(OVERSAMPLE);
        rx = 1'b1;
    endtask

    task automatic expect_frame(input string name, input logic [7:0] exp_data,
                                input logic exp_ferr);
        logic [DATA_BITS:0] c;
        check({name, "_count"}, 32'(capq.size()), 32'd1);
        if (capq.size() > 0) begin
            c = capq.pop_front();
            check({name, "_data"}, {24'd0, c[7:0]}, {24'd0, exp_data});
            check({name, "_ferr"}, {31'd0, c[8]}, {31'd0, exp_ferr});
        end
        capq.delete();
    endtask

    initial begin
        logic [7:0]         b;
        logic [DATA_BITS:0] c;

        vecs[0] = '{8'h55, 1'b1, 4,  8'h55, 1'b0};
        vecs[1] = '{8'hA3, 1'b0, 20, 8'hA3, 1'b1};
        vecs[2] = '{8'h0F, 1'b1, 4,  8'h0F, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 0,  8'h00, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 0,  8'hFF, 1'b0};
        vecs[5] = '{8'h81, 1'b1, 2,  8'h81, 1'b0};

        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("rst_data",  {24'd0, rx_data}, 32'd0);
        check("rst_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_ferr",  {31'd0, frame_err}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wait_ticks(4);

        // Table of frames, including an error frame and a back-to-back pair.
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].stop);
            if (vecs[i].gap > 0) wait_ticks(vecs[i].gap);
            expect_frame($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_ferr);
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
        end

        // Short low pulse: start detected, then rejected at mid-bit.
        wait_ticks(4);
        rx = 1'b0;
        wait_ticks(2);
        check("glitch_busy_hi", {31'd0, busy}, 32'd1);
        wait_ticks(2);
        rx = 1'b1;
        wait_ticks(6);
        check("glitch_busy_lo", {31'd0, busy}, 32'd0);
        check("glitch_novalid", 32'(capq.size()), 32'd0);
        capq.delete();

        // Line break: two full zero frames flagged as framing errors, third rejected.
        wait_ticks(4);
        rx = 1'b0;
        wait_ticks(310);
        rx = 1'b1;
        wait_ticks(40);
        check("break_count", 32'(capq.size()), 32'd2);
        while (capq.size() > 0) begin
            c = capq.pop_front();
            check("break_data", {24'd0, c[7:0]}, 32'd0);
            check("break_ferr", {31'd0, c[8]}, 32'd1);
        end
        check("break_busy", {31'd0, busy}, 32'd0);

        // Reset during data bit 4 of 0x3C: frame discarded, outputs cleared.
        b  = 8'h3C;
        rx = 1'b0;
        wait_ticks(OVERSAMPLE);
        for (int k = 0; k < 4; k++) begin
            rx = b[k];
            wait_ticks(OVERSAMPLE);
        end
        rx = b[4];
        wait_ticks(8);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_data",  {24'd0, rx_data}, 32'd0);
        check("mid_rst_valid", {31'd0, rx_valid}, 32'd0);
        check("mid_rst_ferr",  {31'd0, frame_err}, 32'd0);
        check("mid_rst_busy",  {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wait_ticks(8);
        rx = 1'b1;
        wait_ticks(200);
        check("rst_discard", 32'(capq.size()), 32'd0);
        capq.delete();
        send_frame(8'h3C, 1'b1);
        wait_ticks(4);
        expect_frame("after_rst", 8'h3C, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
